// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the Baccarat round controller: FSM state
// encoding, card width and card-value / modulo-10 scoring helpers.
package baccarat_pkg;

  localparam int unsigned CARD_W      = 4;
  localparam int unsigned NATURAL_MIN = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_P1,
    ST_D1,
    ST_P2,
    ST_D2,
    ST_EVAL,
    ST_P3,
    ST_D3,
    ST_RESULT
  } state_t;

  // Pip value of a rank: Ace..9 count face value, tens/faces and illegal ranks count zero.
  function automatic logic [CARD_W-1:0] card_value(input logic [CARD_W-1:0] rank);
    return ((rank >= CARD_W'(1)) && (rank <= CARD_W'(9))) ? rank : '0;
  endfunction

  function automatic logic [CARD_W-1:0] add_mod10(input logic [CARD_W-1:0] a,
                                                  input logic [CARD_W-1:0] b);
    logic [CARD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (CARD_W+1)'(10)) s = s - (CARD_W+1)'(10);
    return s[CARD_W-1:0];
  endfunction

endpackage

// File: rtl/baccarat_draw_rules.sv
// Dealer third-card decision: the punto-banco tableau when the player drew,
// otherwise the plain "draw on 0-5" rule.
module baccarat_draw_rules
  import baccarat_pkg::*;
(
  input  logic [CARD_W-1:0] dscore,
  input  logic [CARD_W-1:0] v,
  input  logic              player_drew,
  output logic              dealer_draw
);

  always_comb begin
    dealer_draw = 1'b0;
    if (!player_drew) begin
      dealer_draw = (dscore <= CARD_W'(5));
    end else begin
      case (dscore)
        CARD_W'(0), CARD_W'(1), CARD_W'(2): dealer_draw = 1'b1;
        CARD_W'(3): dealer_draw = (v != CARD_W'(8));
        CARD_W'(4): dealer_draw = (v >= CARD_W'(2)) && (v <= CARD_W'(7));
        CARD_W'(5): dealer_draw = (v >= CARD_W'(4)) && (v <= CARD_W'(7));
        CARD_W'(6): dealer_draw = (v >= CARD_W'(6)) && (v <= CARD_W'(7));
        default:    dealer_draw = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/baccarat_round_ctrl.sv
// Punto-banco round controller: deals cards over a valid/ready handshake,
// keeps running scores, applies the third-card rules and keeps win statistics.
module baccarat_round_ctrl
  import baccarat_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter bit          AUTO_RESTART = 1'b0
) (
  input  logic              slow_clock,
  input  logic              resetb,
  input  logic              start,
  input  logic              clear_stats,
  input  logic              card_valid,
  input  logic [CARD_W-1:0] card_rank,
  output logic              card_ready,
  output logic              load_pcard1,
  output logic              load_pcard2,
  output logic              load_pcard3,
  output logic              load_dcard1,
  output logic              load_dcard2,
  output logic              load_dcard3,
  output logic [CARD_W-1:0] pscore,
  output logic [CARD_W-1:0] dscore,
  output logic              player_win_light,
  output logic              dealer_win_light,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  player_wins,
  output logic [CNT_W-1:0]  dealer_wins,
  output logic [CNT_W-1:0]  ties
);

  state_t            r_state;
  state_t            w_next;
  logic [CARD_W-1:0] r_pscore, r_dscore, r_v;
  logic              r_plight, r_dlight;
  logic [CNT_W-1:0]  r_pwins, r_dwins, r_ties;

  logic              w_xfer;
  logic [CARD_W-1:0] w_value, w_p_next, w_d_next, w_v_sel;
  logic              w_player_drew, w_dealer_draw, w_natural;
  logic              w_enter_p1, w_enter_result, w_p_gt, w_d_gt;

  assign card_ready = r_state inside {ST_P1, ST_D1, ST_P2, ST_D2, ST_P3, ST_D3};
  assign busy       = !(r_state inside {ST_IDLE, ST_RESULT});
  assign done       = (r_state == ST_RESULT);
  assign w_xfer     = card_valid && card_ready;
  assign w_value    = card_value(card_rank);

  assign load_pcard1 = w_xfer && (r_state == ST_P1);
  assign load_dcard1 = w_xfer && (r_state == ST_D1);
  assign load_pcard2 = w_xfer && (r_state == ST_P2);
  assign load_dcard2 = w_xfer && (r_state == ST_D2);
  assign load_pcard3 = w_xfer && (r_state == ST_P3);
  assign load_dcard3 = w_xfer && (r_state == ST_D3);

  // At the P3 transfer the card is not yet in r_v, so the rule sees the live value.
  assign w_player_drew = (r_state == ST_P3);
  assign w_v_sel       = w_player_drew ? w_value : r_v;
  assign w_natural     = (r_pscore >= CARD_W'(NATURAL_MIN)) ||
                         (r_dscore >= CARD_W'(NATURAL_MIN));

  baccarat_draw_rules u_draw_rules (
    .dscore      (r_dscore),
    .v           (w_v_sel),
    .player_drew (w_player_drew),
    .dealer_draw (w_dealer_draw)
  );

  always_comb begin
    w_p_next = r_pscore;
    w_d_next = r_dscore;
    if (w_xfer) begin
      if (r_state inside {ST_P1, ST_P2, ST_P3}) w_p_next = add_mod10(r_pscore, w_value);
      else                                      w_d_next = add_mod10(r_dscore, w_value);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_P1;
      ST_P1:     if (w_xfer) w_next = ST_D1;
      ST_D1:     if (w_xfer) w_next = ST_P2;
      ST_P2:     if (w_xfer) w_next = ST_D2;
      ST_D2:     if (w_xfer) w_next = ST_EVAL;
      ST_EVAL: begin
        if (w_natural)                    w_next = ST_RESULT;
        else if (r_pscore <= CARD_W'(5))  w_next = ST_P3;
        else if (w_dealer_draw)           w_next = ST_D3;
        else                              w_next = ST_RESULT;
      end
      ST_P3:     if (w_xfer) w_next = w_dealer_draw ? ST_D3 : ST_RESULT;
      ST_D3:     if (w_xfer) w_next = ST_RESULT;
      ST_RESULT: if (start || AUTO_RESTART) w_next = ST_P1;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign w_enter_p1     = (w_next == ST_P1)     && (r_state != ST_P1);
  assign w_enter_result = (w_next == ST_RESULT) && (r_state != ST_RESULT);
  assign w_p_gt         = (w_p_next > w_d_next);
  assign w_d_gt         = (w_d_next > w_p_next);

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_state  <= ST_IDLE;
      r_pscore <= '0;
      r_dscore <= '0;
      r_v      <= '0;
      r_plight <= 1'b0;
      r_dlight <= 1'b0;
      r_pwins  <= '0;
      r_dwins  <= '0;
      r_ties   <= '0;
    end else begin
      r_state <= w_next;

      if (w_enter_p1) begin
        r_pscore <= '0;
        r_dscore <= '0;
        r_plight <= 1'b0;
        r_dlight <= 1'b0;
      end else begin
        r_pscore <= w_p_next;
        r_dscore <= w_d_next;
        if (w_enter_result) begin
          r_plight <= !w_d_gt;
          r_dlight <= !w_p_gt;
        end
      end

      if (w_xfer && (r_state == ST_P3)) r_v <= w_value;

      if (clear_stats) begin
        r_pwins <= '0;
        r_dwins <= '0;
        r_ties  <= '0;
      end else if (w_enter_result) begin
        if (w_p_gt) begin
          if (r_pwins != '1) r_pwins <= r_pwins + CNT_W'(1);
        end else if (w_d_gt) begin
          if (r_dwins != '1) r_dwins <= r_dwins + CNT_W'(1);
        end else begin
          if (r_ties != '1) r_ties <= r_ties + CNT_W'(1);
        end
      end
    end
  end

  assign pscore           = r_pscore;
  assign dscore           = r_dscore;
  assign player_win_light = r_plight;
  assign dealer_win_light = r_dlight;
  assign player_wins      = r_pwins;
  assign dealer_wins      = r_dwins;
  assign ties             = r_ties;

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Self-checking bench for baccarat_round_ctrl against a hand-level model of
// punto-banco play (card order, final totals, winner, saturating statistics).
module tb_baccarat_round_ctrl;

  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, clear_stats, card_valid;
  logic [3:0]    card_rank;
  logic          card_ready, lp1, lp2, lp3, ld1, ld2, ld3;
  logic [3:0]    pscore, dscore;
  logic          pl, dl, busy, done;
  logic [CW-1:0] pw, dw, tw;
  logic [5:0]    loads;
  logic [24:0]   zvec;

  assign loads = {ld3, lp3, ld2, lp2, ld1, lp1};
  assign zvec  = {pscore, dscore, pl, dl, card_ready, busy, done, loads, pw, dw, tw};

  baccarat_round_ctrl #(.CNT_W(CW), .AUTO_RESTART(1'b0)) dut (
    .slow_clock(clk), .resetb(rst_n), .start(start), .clear_stats(clear_stats),
    .card_valid(card_valid), .card_rank(card_rank), .card_ready(card_ready),
    .load_pcard1(lp1), .load_pcard2(lp2), .load_pcard3(lp3),
    .load_dcard1(ld1), .load_dcard2(ld2), .load_dcard3(ld3),
    .pscore(pscore), .dscore(dscore),
    .player_win_light(pl), .dealer_win_light(dl),
    .busy(busy), .done(done),
    .player_wins(pw), .dealer_wins(dw), .ties(tw)
  );

  logic       a_start, a_clear, a_valid;
  logic [3:0] a_rank;
  logic       a_ready, a_lp1, a_lp2, a_lp3, a_ld1, a_ld2, a_ld3;
  logic [3:0] a_pscore, a_dscore;
  logic       a_pl, a_dl, a_busy, a_done;
  logic [7:0] a_pw, a_dw, a_tw;

  baccarat_round_ctrl #(.CNT_W(8), .AUTO_RESTART(1'b1)) dut_auto (
    .slow_clock(clk), .resetb(rst_n), .start(a_start), .clear_stats(a_clear),
    .card_valid(a_valid), .card_rank(a_rank), .card_ready(a_ready),
    .load_pcard1(a_lp1), .load_pcard2(a_lp2), .load_pcard3(a_lp3),
    .load_dcard1(a_ld1), .load_dcard2(a_ld2), .load_dcard3(a_ld3),
    .pscore(a_pscore), .dscore(a_dscore),
    .player_win_light(a_pl), .dealer_win_light(a_dl),
    .busy(a_busy), .done(a_done),
    .player_wins(a_pw), .dealer_wins(a_dw), .ties(a_tw)
  );

  int total = 0;
  int bad   = 0;

  int cards[$];
  int m_slots[$];
  int m_p, m_d, m_win;
  int cnt_p = 0, cnt_d = 0, cnt_t = 0;

  function automatic int cval(input int r);
    return (r >= 1 && r <= 9) ? r : 0;
  endfunction

  function automatic bit banker_draws(input int d, input int v);
    if (d <= 2) return 1'b1;
    if (d == 3) return v != 8;
    if (d >= 4 && d <= 6) return (v >= 2 * (d - 3)) && (v <= 7);
    return 1'b0;
  endfunction

  // Plays the whole hand from the card list: slot order, final totals, winner.
  task automatic model_hand();
    int p, d, v, nxt;
    m_slots.delete();
    for (int i = 0; i < 4; i++) m_slots.push_back(i);
    p = (cval(cards[0]) + cval(cards[2])) % 10;
    d = (cval(cards[1]) + cval(cards[3])) % 10;
    nxt = 4;
    if (p < 8 && d < 8) begin
      if (p <= 5) begin
        v = cval(cards[nxt]); nxt++;
        p = (p + v) % 10;
        m_slots.push_back(4);
        if (banker_draws(d, v)) begin
          d = (d + cval(cards[nxt])) % 10;
          m_slots.push_back(5);
        end
      end else if (d <= 5) begin
        d = (d + cval(cards[nxt])) % 10;
        m_slots.push_back(5);
      end
    end
    m_p = p;
    m_d = d;
    m_win = (p > d) ? 0 : (p < d) ? 1 : 2;
  endtask

  // stall_mode: 0 = valid always high, 1 = random gaps, 2 = five idle cycles in D1.
  task automatic play_round(input int stall_mode, input int clear_edge, output int edges);
    int k, rp, rd, lowcnt, exp_l, slot;
    model_hand();
    k = 0; rp = 0; rd = 0; lowcnt = 0; edges = 0;
    start = 1'b1;
    card_valid = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      edges++;
      start = 1'b0; clear_stats = 1'b0; card_valid = 1'b0;
      if (done) break;
      if (edges > 300) begin
        total++; bad++;
        $display("FAIL round_timeout got edges=%0d want done within 300", edges);
        break;
      end
      total++;
      if (pscore !== 4'(rp) || dscore !== 4'(rd)) begin
        bad++;
        $display("FAIL running_scores got p=%0d d=%0d want p=%0d d=%0d", pscore, dscore, rp, rd);
      end
      case (stall_mode)
        1:       card_valid = ($urandom_range(0, 3) != 0);
        2:       card_valid = !(k == 1 && lowcnt < 5);
        default: card_valid = 1'b1;
      endcase
      if (stall_mode == 2 && !card_valid) lowcnt++;
      card_rank = (k < cards.size()) ? 4'(cards[k]) : 4'd0;
      if (clear_edge == edges + 1) clear_stats = 1'b1;
      #1;
      total++;
      if (card_valid && card_ready) begin
        slot  = (k < m_slots.size()) ? m_slots[k] : -1;
        exp_l = (slot >= 0) ? (1 << slot) : 0;
        if (loads !== 6'(exp_l)) begin
          bad++;
          $display("FAIL load_pulse got %b want %b (card %0d)", loads, 6'(exp_l), k);
        end
        if (slot >= 0) begin
          if (slot % 2 == 0) rp = (rp + cval(cards[k])) % 10;
          else               rd = (rd + cval(cards[k])) % 10;
        end
        k++;
      end else if (loads !== 6'b0) begin
        bad++;
        $display("FAIL load_idle got %b want 000000", loads);
      end
    end
    start = 1'b0; clear_stats = 1'b0; card_valid = 1'b0;

    if (clear_edge > 0) begin
      cnt_p = 0; cnt_d = 0; cnt_t = 0;
    end else begin
      case (m_win)
        0:       if (cnt_p < MAXC) cnt_p++;
        1:       if (cnt_d < MAXC) cnt_d++;
        default: if (cnt_t < MAXC) cnt_t++;
      endcase
    end

    total++;
    if (k != m_slots.size()) begin
      bad++;
      $display("FAIL cards_used got %0d want %0d", k, m_slots.size());
    end
    total++;
    if (pscore !== 4'(m_p) || dscore !== 4'(m_d)) begin
      bad++;
      $display("FAIL final_scores got p=%0d d=%0d want p=%0d d=%0d", pscore, dscore, m_p, m_d);
    end
    total++;
    if ({pl, dl} !== ((m_win == 0) ? 2'b10 : (m_win == 1) ? 2'b01 : 2'b11)) begin
      bad++;
      $display("FAIL lights got pl=%0b dl=%0b want winner code %0d", pl, dl, m_win);
    end
    total++;
    if (pw !== CW'(cnt_p) || dw !== CW'(cnt_d) || tw !== CW'(cnt_t)) begin
      bad++;
      $display("FAIL counters got p=%0d d=%0d t=%0d want p=%0d d=%0d t=%0d",
               pw, dw, tw, cnt_p, cnt_d, cnt_t);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; clear_stats = 1'b0; card_valid = 1'b0; card_rank = 4'd0;
    a_start = 1'b0; a_clear = 1'b0; a_valid = 1'b0; a_rank = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (zvec !== 25'd0) begin
      bad++;
      $display("FAIL reset_hold got %h want 0", zvec);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (zvec !== 25'd0) begin
      bad++;
      $display("FAIL idle_after_reset got %h want 0", zvec);
    end
  endtask

  task automatic test_directed();
    int e;
    cards = '{8, 3, 13, 2};
    play_round(0, -1, e);
    total++;
    if (e != 6) begin
      bad++;
      $display("FAIL natural_latency got %0d want 6", e);
    end
    cards = '{2, 3, 3, 13, 8};
    play_round(0, -1, e);
    total++;
    if (tw !== CW'(1) || pscore !== 4'd3 || dscore !== 4'd3) begin
      bad++;
      $display("FAIL tie_hand got t=%0d p=%0d d=%0d want t=1 p=3 d=3", tw, pscore, dscore);
    end
    cards = '{1, 4, 1, 2, 6, 5};
    play_round(0, -1, e);
    total++;
    if (e != 8) begin
      bad++;
      $display("FAIL six_card_latency got %0d want 8", e);
    end
  endtask

  task automatic new_random_hand();
    cards.delete();
    for (int i = 0; i < 6; i++) cards.push_back(int'($urandom_range(0, 15)));
  endtask

  task automatic test_stall();
    int e;
    cards = '{1, 4, 1, 2, 6, 5};
    play_round(2, -1, e);
    for (int n = 0; n < 40; n++) begin
      new_random_hand();
      play_round(1, -1, e);
    end
  endtask

  task automatic test_latency();
    int e;
    for (int n = 0; n < 12; n++) begin
      new_random_hand();
      play_round(0, -1, e);
      total++;
      if (e != m_slots.size() + 2) begin
        bad++;
        $display("FAIL latency got %0d want %0d", e, m_slots.size() + 2);
      end
    end
  endtask

  task automatic test_saturation();
    int e;
    cards = '{2, 9, 13, 13};
    for (int n = 0; n < 4; n++) play_round(0, -1, e);
    total++;
    if (dw !== 2'd3) begin
      bad++;
      $display("FAIL dealer_saturate got %0d want 3", dw);
    end
  endtask

  task automatic test_clear();
    int e;
    cards = '{8, 3, 13, 2};
    play_round(0, 6, e);
    total++;
    if ({pw, dw, tw} !== '0) begin
      bad++;
      $display("FAIL clear_on_result got %b want 0", {pw, dw, tw});
    end
  endtask

  task automatic test_reset_mid_p3();
    cards = '{2, 3, 3, 13, 8};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    card_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      card_rank = 4'(cards[k]);
      @(posedge clk); #1;
    end
    card_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (card_ready !== 1'b1 || busy !== 1'b1 || pscore !== 4'd5) begin
      bad++;
      $display("FAIL p3_reached got ready=%0b busy=%0b p=%0d want 1 1 5", card_ready, busy, pscore);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (zvec !== 25'd0) begin
      bad++;
      $display("FAIL async_reset got %h want 0", zvec);
    end
    cnt_p = 0; cnt_d = 0; cnt_t = 0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_mid_reset got busy=%0b done=%0b want 0 0", busy, done);
    end
  endtask

  task automatic test_auto_restart();
    int n;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_valid = 1'b1;
    a_rank  = 4'd9;
    n = 0;
    while (!a_done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (!a_done || {a_pl, a_dl} !== 2'b11 || a_tw !== 8'd1) begin
      bad++;
      $display("FAIL auto_result got done=%0b lights=%b ties=%0d want 1 11 1", a_done, {a_pl, a_dl}, a_tw);
    end
    @(posedge clk); #1;
    total++;
    if (a_done !== 1'b0 || a_busy !== 1'b1 || a_ready !== 1'b1 || a_pscore !== 4'd0) begin
      bad++;
      $display("FAIL auto_restart got done=%0b busy=%0b ready=%0b p=%0d want 0 1 1 0",
               a_done, a_busy, a_ready, a_pscore);
    end
    a_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_latency();
    test_saturation();
    test_clear();
    test_reset_mid_p3();
    test_auto_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/baccarat_round_ctrl.md
# baccarat_round_ctrl

Parametrised round controller for the Baccarat engine: it sequences a complete punto-banco hand from an external card source over a valid/ready handshake, accumulates player and dealer scores internally, applies the full third-card tableau, drives the win lights, and keeps saturating win/tie statistics across rounds. It sits between the card dealer (RNG/shoe) and the score displays/lights, replacing the fixed single-round state machine.

## Interface
- CNT_W, default 8: width of each statistics counter.
- AUTO_RESTART, default 0: when 1, RESULT is followed by a new deal without waiting for `start`.
- slow_clock  in  1  sole clock, rising edge.
- resetb  in  1  asynchronous, active-low reset.
- start  in  1  begin a round; sampled in IDLE or RESULT only.
- clear_stats  in  1  synchronous clear of all statistics counters.
- card_valid  in  1  card source has a card on `card_rank`.
- card_rank  in  4  rank, 1=Ace … 13=King.
- card_ready  out  1  controller wants a card (high in deal states only).
- load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3  out  1 each  one-cycle pulse on the transfer cycle for that slot.
- pscore, dscore  out  4  running hand totals, 0–9.
- player_win_light, dealer_win_light  out  1  result; both high means tie.
- busy  out  1  round in progress (any state other than IDLE/RESULT).
- done  out  1  high while in RESULT.
- player_wins, dealer_wins, ties  out  CNT_W  saturating statistics.

## Operation
- States: IDLE, P1, D1, P2, D2, EVAL, P3, D3, RESULT.
- Transfer = `card_valid & card_ready`. In P1/D1/P2/D2/P3/D3, `card_ready`=1; state advances only on a transfer; stalls indefinitely otherwise.
- Card value: ranks 1–9 → rank; 10–13 → 0; rank 0 or 14–15 → 0.
- On transfer, the corresponding score updates to (score + value) mod 10.
- IDLE/RESULT + `start` → P1; entering P1 clears pscore, dscore and both lights.
- D2 → EVAL unconditionally after transfer.
- EVAL, using the pscore/dscore registers holding both two-card totals:
  - pscore≥8 or dscore≥8 (natural) → RESULT.
  - else pscore≤5 → P3.
  - else (player stands) dscore≤5 → D3, otherwise RESULT.
- P3 → after transfer, the dealer rule uses the value v of player card 3 (held in an internal register) and dscore:
  - dscore 0–2: draw.
  - dscore 3: draw unless v=8.
  - dscore 4: draw if v∈2..7.
  - dscore 5: draw if v∈4..7.
  - dscore 6: draw if v∈6..7.
  - dscore 7: stand.
  - Draw → D3, stand → RESULT.
- D3 → RESULT after transfer.
- RESULT entry (one cycle): compare pscore/dscore and set lights (player>dealer: player light only; dealer>player: dealer light only; equal: both). Increment exactly one counter, saturating at all-ones.
- RESULT exits to P1 on `start`, or automatically on the next cycle when AUTO_RESTART=1. Lights hold until P1 entry.
- `clear_stats` zeroes all counters the next edge; it wins over a simultaneous increment.
- `start` while busy is ignored.

## Timing
- Reset (async assert, any state including mid-deal): state=IDLE; pscore=dscore=0; all lights, loads, `card_ready`, `busy`, `done` = 0; counters=0; v register=0.
- `load_*` are combinational from state & transfer: high in the transfer cycle, so display registers capture on the same edge as the score update.
- Scores are registered: visible the cycle after transfer.
- EVAL lasts exactly 1 cycle.
- Lights and counter update are visible the first cycle `done`=1.
- Minimum round latency with `card_valid` tied high:
  - 4-card hand: 4 transfer cycles + EVAL + RESULT, `start` to `done` = 6 cycles.
  - 6-card hand: 8 cycles.

## Structure
- Package `baccarat_pkg`: state enum, `card_value(rank)` function, `CARD_W`=4 constant, `NATURAL_MIN`=8.
- Sub-module `baccarat_draw_rules` (combinational): inputs dscore, v, player_drew; output dealer_draw. Instantiated once, checked exhaustively by a separate bench.
- Top contains FSM, score/v registers, counters.

## Test plan
- Natural: cards 8,3,K,2 → P1/D1/P2/D2 loads in order; EVAL→RESULT; pscore=8, dscore=5; player light only; player_wins=1.
- Player draws, dealer stands on v=8: cards 2,3,3,K,8 (p=5, d=3, v=8) → no D3; pscore=3, dscore=3; tie, both lights; ties=1.
- Player draws, dealer draws: cards A,4,A,2,6,5 (p=2, d=6, v=6) → D3 loaded; pscore=8, dscore=1; player wins.
- Handshake stall: `card_valid` low for 5 cycles in D1 → state, scores and loads frozen; resumes on valid. Reset asserted mid-P3 → all outputs zero immediately, IDLE.
- Saturation/clear: CNT_W=2, 4 dealer wins → dealer_wins=3. `clear_stats` in the RESULT-entry cycle → 0. AUTO_RESTART=1 → P1 one cycle after RESULT without `start`.
